multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter M_EXT, default 1; 1 enables RV32M decode and the MDU_WAIT state, 0 decodes RV32M as illegal.
REQ-002 Parameter MEM_TIMEOUT, default 16; maximum cycles waiting on mem_ready before trap, range 2..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 instr  in  32  instruction register contents, valid from DECODE onward.
REQ-006 mem_ready  in  1  memory handshake completion for the current mem_req.
REQ-007 mdu_done  in  1  multiply/divide unit result valid, one-cycle pulse.
REQ-008 Output ports (direction out):
  - mem_req 1: memory access request.
  - mem_we 1: store access.
  - addr_sel 1: 0 = PC, 1 = ALU result.
  - ir_write 1: latch the instruction register.
  - pc_write 1: unconditional PC update.
  - pc_write_cond 1: branch-qualified PC update.
  - reg_write 1: register-file write.
  - alu_src_a 2: 0 = rs1, 1 = PC, 2 = zero.
  - alu_src_b 2: 0 = rs2, 1 = imm, 2 = constant 4.
  - alu_op 4: ALU operation class.
  - wb_sel 2: 0 = ALU, 1 = memory, 2 = PC+4, 3 = MDU.
  - mdu_start 1: one-cycle MDU launch pulse.
  - trap 1: illegal-opcode or memory-timeout flag.
  - state 3: current FSM state, for debug.

Function
REQ-009 FSM states:
  - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5, TRAP=6.
  - Encodings 7 and unused fall to TRAP.
REQ-010 FETCH behaviour:
  - Assert mem_req with addr_sel=0.
  - On the cycle mem_ready=1, assert ir_write and pc_write with alu_src_a=1, alu_src_b=2, and go to DECODE.
  - Otherwise stay in FETCH.
REQ-011 DECODE: opcode = instr[6:2], with instr[1:0] required to be 2'b11; no side effects; next state EXEC, or TRAP if illegal.
REQ-012 Legal opcodes: Arith_R 01100, Arith_I 00100, Load 00000, Store 01000, Branch 11000, JAL 11011, JALR 11001, AUIPC 00101, LUI 01101; any other value is illegal.
REQ-013 EXEC Arith_R/Arith_I: alu_src_a=0, alu_src_b=0 (R) or 1 (I); next state WB.
REQ-014 EXEC Arith_R with funct7=0000001 and M_EXT=1: assert mdu_start for exactly one cycle, then go to MDU_WAIT.
REQ-015 MDU_WAIT: hold until mdu_done=1, then go to WB with wb_sel=3.
REQ-016 EXEC Load/Store: compute address with alu_src_a=0, alu_src_b=1; next state MEM.
REQ-017 EXEC Branch: assert pc_write_cond; next state FETCH.
REQ-018 EXEC JAL/JALR: write the target to PC and rd=PC+4 (wb_sel=2), then go to FETCH.
  - Target base is PC for JAL, rs1 for JALR.
  - pc_write and reg_write are asserted in the same cycle.
REQ-019 EXEC AUIPC/LUI: alu_src_a=1 (AUIPC) or 2 (LUI), alu_src_b=1; next state WB.
REQ-020 MEM behaviour:
  - Assert mem_req with addr_sel=1, and mem_we=1 for Store.
  - On mem_ready, Load goes to WB with wb_sel=1; Store goes to FETCH.
REQ-021 WB: assert reg_write for exactly one cycle; next state FETCH.
REQ-022 Memory wait counter (8-bit):
  - Clears on entry to FETCH or MEM.
  - Increments on each cycle mem_req=1 and mem_ready=0.
  - Reaching MEM_TIMEOUT goes to TRAP.
REQ-023 TRAP: trap=1 with all write/request outputs 0; remains in TRAP until rst.
REQ-024 Outputs are a registered-state Moore decode plus instr, with no combinational path from mem_ready/mdu_done except FETCH ir_write/pc_write and the MEM exit.
REQ-025 Ignored inputs: mem_ready is ignored when mem_req=0, and mdu_done is ignored outside MDU_WAIT.
REQ-026 Simultaneity: mem_ready=1 on the same cycle the counter hits MEM_TIMEOUT completes the access; there is no trap.

Reset
REQ-027 While rst=1, at the next clk edge: state=FETCH, wait counter=0, all outputs 0 except state=0.
REQ-028 rst asserted mid-MEM or mid-MDU_WAIT abandons the access with no reg_write or pc_write.
REQ-029 A new fetch begins on the first cycle after rst deasserts.

Structure
REQ-030 A shared package rv_ctrl_pkg holds the state enum, opcode constants, and the alu_op and wb_sel encodings.
REQ-031 A combinational sub-module rv_decode (instr -> opcode class, illegal, is_mdu) is instantiated once.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3) with mem_ready=1 every request: states 0,1,2,4,0; reg_write high in cycle 4 only.
REQ-033 LW x5,8(x1) (0x0080A283) with mem_ready delayed 3 cycles in MEM: MEM lasts 4 cycles, then WB with wb_sel=1.
REQ-034 MUL x4,x1,x2 (0x02208233), M_EXT=1, mdu_done 5 cycles after start: single mdu_start pulse, then WB with wb_sel=3.
REQ-035 Same MUL with M_EXT=0: DECODE goes to TRAP; trap=1 persists with no writes.
REQ-036 Memory stall: mem_ready held 0 in FETCH, MEM_TIMEOUT=4: TRAP after 4 waiting cycles.
  - Variant: mem_ready=1 on the 4th waiting cycle instead proceeds to DECODE.
REQ-037 rst pulsed during MDU_WAIT: the next cycle is FETCH, and no reg_write occurs.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control FSM: states, opcodes,
// instruction classes and datapath select/operation codes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM      = 3'd3,
        ST_WB       = 3'd4,
        ST_MDU_WAIT = 3'd5,
        ST_TRAP     = 3'd6
    } state_e;

    localparam logic [4:0] OPC_ARITH_R = 5'b01100;
    localparam logic [4:0] OPC_ARITH_I = 5'b00100;
    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_LUI     = 5'b01101;

    localparam logic [6:0] FUNCT7_MDU  = 7'b0000001;

    typedef enum logic [3:0] {
        CLS_ARITH_R,
        CLS_ARITH_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_AUIPC,
        CLS_LUI,
        CLS_ILLEGAL
    } op_class_e;

    // ALU operation classes; the ALU refines R/I ops from funct3/funct7 itself.
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_FUNCT_R = 4'd1;
    localparam logic [3:0] ALU_FUNCT_I = 4'd2;
    localparam logic [3:0] ALU_BRANCH  = 4'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_MDU = 2'd3;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/rv_decode.sv
// Combinational opcode classifier: instruction word -> class, illegal flag,
// and whether it is an RV32M multiply/divide.
module rv_decode
    import rv_ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] instr_i,
    output op_class_e   op_class_o,
    output logic        illegal_o,
    output logic        is_mdu_o
);

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[24:7];

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        if (instr_i[1:0] == 2'b11) begin
            case (instr_i[6:2])
                OPC_ARITH_R: op_class_o = CLS_ARITH_R;
                OPC_ARITH_I: op_class_o = CLS_ARITH_I;
                OPC_LOAD:    op_class_o = CLS_LOAD;
                OPC_STORE:   op_class_o = CLS_STORE;
                OPC_BRANCH:  op_class_o = CLS_BRANCH;
                OPC_JAL:     op_class_o = CLS_JAL;
                OPC_JALR:    op_class_o = CLS_JALR;
                OPC_AUIPC:   op_class_o = CLS_AUIPC;
                OPC_LUI:     op_class_o = CLS_LUI;
                default:     op_class_o = CLS_ILLEGAL;
            endcase
        end
    end

    assign is_mdu_o  = (op_class_o == CLS_ARITH_R) && (instr_i[31:25] == FUNCT7_MDU);
    // Without the M extension, MUL/DIV encodings are simply unknown instructions.
    assign illegal_o = (op_class_o == CLS_ILLEGAL) || (is_mdu_o && (M_EXT == 0));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I(+M) control FSM: FETCH/DECODE/EXEC/MEM/WB with optional
// MDU wait, memory-stall timeout and a sticky TRAP state.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int M_EXT       = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        mdu_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        mdu_start,
    output logic        trap,
    output logic [2:0]  state
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    op_class_e op_class;
    logic      illegal;
    logic      is_mdu;
    logic      use_mdu;
    logic      mem_wait;
    logic      timeout_hit;

    rv_decode #(.M_EXT(M_EXT)) u_decode (
        .instr_i    (instr),
        .op_class_o (op_class),
        .illegal_o  (illegal),
        .is_mdu_o   (is_mdu)
    );

    assign use_mdu     = (M_EXT != 0) && is_mdu;
    assign mem_wait    = mem_req && !mem_ready;
    // A ready on the would-be timeout cycle still wins over the trap.
    assign timeout_hit = mem_wait && (wait_cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;
        wb_sel        = WB_ALU;
        mdu_start     = 1'b0;
        trap          = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d  = ST_TRAP;
                end
            end
            ST_DECODE: state_d = illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                case (op_class)
                    CLS_ARITH_R: begin
                        if (use_mdu) begin
                            mdu_start = 1'b1;
                            state_d   = ST_MDU_WAIT;
                        end else begin
                            alu_op  = ALU_FUNCT_R;
                            state_d = ST_WB;
                        end
                    end
                    CLS_ARITH_I: begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_FUNCT_I;
                        state_d   = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op        = ALU_BRANCH;
                        pc_write_cond = 1'b1;
                        state_d       = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        alu_src_a = (op_class == CLS_JAL) ? SRCA_PC : SRCA_RS1;
                        alu_src_b = SRCB_IMM;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                        state_d   = ST_FETCH;
                    end
                    CLS_AUIPC, CLS_LUI: begin
                        alu_src_a = (op_class == CLS_AUIPC) ? SRCA_PC : SRCA_ZERO;
                        alu_src_b = SRCB_IMM;
                        state_d   = ST_WB;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (op_class == CLS_STORE);
                alu_src_b = SRCB_IMM;
                if (mem_ready) begin
                    state_d = (op_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (op_class == CLS_LOAD)  wb_sel = WB_MEM;
                else if (use_mdu)          wb_sel = WB_MDU;
                else                       wb_sel = WB_ALU;
                state_d = ST_FETCH;
            end
            ST_MDU_WAIT: begin
                if (mdu_done) state_d = ST_WB;
            end
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_TRAP;
        endcase

        // Only FETCH and MEM stall on memory, so clearing on any transition
        // is the same as clearing on entry to those two states.
        if (state_d != state_q) wait_cnt_d = '0;
        else if (mem_wait)      wait_cnt_d = wait_cnt_q + 8'd1;
        else                    wait_cnt_d = wait_cnt_q;

        // Reset quiets every control line so nothing is written or requested.
        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            addr_sel      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = SRCA_RS1;
            alu_src_b     = SRCB_RS2;
            alu_op        = ALU_ADD;
            wb_sel        = WB_ALU;
            mdu_start     = 1'b0;
            trap          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign state = state_q;

endmodule
